fire_control: RTL and testbench

- Upstream stage of the per-tank bullet pool; one instance per tank.
- Turns that tank's fire-key presses, decoded from the 32-bit keycode word, into one-frame create pulses for individual bullet slots.
- Enforces rate limiting, slot allocation and game-end lockout.
- Each create bit drives the create input of one bullet instance; each slot's is_bullet_active returns as the acknowledge.

---
 rtl/fire_control.sv | 176 +++++++++++++++++
 tb/tb_fire_control.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fire_control.sv
// fire_control: per-tank fire-key front end for the bullet pool.
// Turns rising edges of the fire key into single-frame create pulses
// aimed at the lowest free bullet slot. It then waits for that slot to
// report active, and holds off further shots for a cooldown period.
// A nonzero game_end forces the block back to READY and locks out presses.
module fire_control #(
    parameter int          NUM_BULLETS = 5,
    parameter logic [7:0]  FIRE_KEY    = 8'h2C,
    parameter int          COOLDOWN    = 12,
    parameter int          ACK_TIMEOUT = 4
) (
    input  logic                   frame_clk,
    input  logic                   Reset_n,
    input  logic [31:0]            keycode,
    input  logic [1:0]             game_end,
    input  logic [NUM_BULLETS-1:0] bullet_active,
    output logic [NUM_BULLETS-1:0] create,
    output logic                   busy,
    output logic [7:0]             shots_fired,
    output logic [1:0]             state_dbg
);

    typedef enum logic [1:0] {
        ST_READY    = 2'd0,
        ST_FIRE     = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_COOL     = 2'd3
    } state_t;

    localparam int                     SLOT_W    = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
    localparam logic [3:0]             TCNT_LAST = 4'(ACK_TIMEOUT - 1);
    localparam logic [7:0]             CCNT_INIT = 8'(COOLDOWN - 1);
    localparam logic [NUM_BULLETS-1:0] ONE_HOT0  = NUM_BULLETS'(1);

    // True when any of the four packed key bytes matches the fire key.
    // A zero fire key never matches, since 8'h00 means "no key".
    function automatic logic key_hit(input logic [31:0] kc);
        logic hit;
        hit = 1'b0;
        for (int b = 0; b < 4; b++) begin
            hit = hit | (kc[8*b +: 8] == FIRE_KEY);
        end
        return hit & (FIRE_KEY != 8'd0);
    endfunction

    // Index of the lowest set bit of free (0 when none; caller checks any_free).
    function automatic logic [SLOT_W-1:0] lowest_free(input logic [NUM_BULLETS-1:0] free);
        logic [SLOT_W-1:0] idx;
        idx = '0;
        for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
            if (free[i]) begin
                idx = SLOT_W'(i);
            end
        end
        return idx;
    endfunction

    // The shot counter sticks at 255 rather than wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t                   state_q;
    logic                     key_prev_q;
    logic [SLOT_W-1:0]        slot_q;
    logic [3:0]               tcnt_q;
    logic [7:0]               ccnt_q;
    logic [NUM_BULLETS-1:0]   create_q;
    logic                     busy_q;
    logic [7:0]               shots_q;

    logic                     fire_now_s;
    logic                     press_s;
    logic [NUM_BULLETS-1:0]   free_s;
    logic                     any_free_s;
    logic [SLOT_W-1:0]        sel_s;
    logic                     ack_s;
    logic [7:0]               shots_d;

    // Key edge detection, slot selection and acknowledge lookup.
    always_comb begin
        fire_now_s = key_hit(keycode);
        press_s    = fire_now_s & ~key_prev_q;
        free_s     = ~bullet_active;
        any_free_s = |free_s;
        sel_s      = lowest_free(free_s);
        ack_s      = bullet_active[slot_q];
        shots_d    = sat_inc(shots_q);
    end

    // Control FSM with registered create/busy and the shot counter.
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= ST_READY;
            key_prev_q <= 1'b0;
            slot_q     <= '0;
            tcnt_q     <= 4'd0;
            ccnt_q     <= 8'd0;
            create_q   <= '0;
            busy_q     <= 1'b0;
            shots_q    <= 8'd0;
        end else begin
            // The key history tracks every cycle so that a key held through
            // COOL or a lockout does not count as a fresh press afterwards.
            key_prev_q <= fire_now_s;
            if (game_end != 2'b00) begin
                state_q  <= ST_READY;
                create_q <= '0;
                busy_q   <= 1'b0;
                tcnt_q   <= 4'd0;
                ccnt_q   <= 8'd0;
            end else begin
                case (state_q)
                    ST_READY: begin
                        if (press_s && any_free_s) begin
                            slot_q   <= sel_s;
                            create_q <= ONE_HOT0 << sel_s;
                            busy_q   <= 1'b1;
                            state_q  <= ST_FIRE;
                        end else begin
                            // A press with no free slot is dropped, not queued.
                            create_q <= '0;
                            busy_q   <= 1'b0;
                        end
                    end
                    ST_FIRE: begin
                        create_q <= '0;
                        tcnt_q   <= 4'd0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_WAIT_ACK;
                    end
                    ST_WAIT_ACK: begin
                        create_q <= '0;
                        // The acknowledge takes priority over timeout expiry.
                        if (ack_s) begin
                            shots_q <= shots_d;
                            ccnt_q  <= CCNT_INIT;
                            busy_q  <= 1'b1;
                            state_q <= ST_COOL;
                        end else if (tcnt_q == TCNT_LAST) begin
                            tcnt_q  <= 4'd0;
                            busy_q  <= 1'b0;
                            state_q <= ST_READY;
                        end else begin
                            tcnt_q  <= tcnt_q + 4'd1;
                            busy_q  <= 1'b1;
                        end
                    end
                    ST_COOL: begin
                        create_q <= '0;
                        if (ccnt_q == 8'd0) begin
                            busy_q  <= 1'b0;
                            state_q <= ST_READY;
                        end else begin
                            ccnt_q  <= ccnt_q - 8'd1;
                            busy_q  <= 1'b1;
                        end
                    end
                    default: begin
                        create_q <= '0;
                        busy_q   <= 1'b0;
                        tcnt_q   <= 4'd0;
                        ccnt_q   <= 8'd0;
                        state_q  <= ST_READY;
                    end
                endcase
            end
        end
    end

    assign create      = create_q;
    assign busy        = busy_q;
    assign shots_fired = shots_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_fire_control.sv
// Directed testbench for fire_control with hand-computed expectations.
module tb_fire_control;

    logic        frame_clk;
    logic        Reset_n;
    logic [31:0] keycode;
    logic [1:0]  game_end;
    logic [4:0]  bullet_active;
    logic [4:0]  create;
    logic        busy;
    logic [7:0]  shots_fired;
    logic [1:0]  state_dbg;

    int errors;
    int checks;

    fire_control dut (
        .frame_clk    (frame_clk),
        .Reset_n      (Reset_n),
        .keycode      (keycode),
        .game_end     (game_end),
        .bullet_active(bullet_active),
        .create       (create),
        .busy         (busy),
        .shots_fired  (shots_fired),
        .state_dbg    (state_dbg)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    // Advance one frame; sample and drive 1 time unit after the rising edge.
    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; keycode = 32'h0; game_end = 2'b00; bullet_active = 5'b00000;
        repeat (2) @(posedge frame_clk);
        #1;
        checks++; if (create !== 5'b00000) begin errors++; $display("FAIL reset_create: got %b want 00000", create); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (shots_fired !== 8'd0) begin errors++; $display("FAIL reset_shots: got %0d want 0", shots_fired); end
        checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
        Reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_fire();
        keycode = 32'h0000_002C;
        tick();
        checks++; if (create !== 5'b00001) begin errors++; $display("FAIL basic_create: got %b want 00001", create); end
        checks++; if (state_dbg !== 2'd1 || busy !== 1'b1) begin errors++; $display("FAIL basic_fire_state: got st=%0d busy=%b want st=1 busy=1", state_dbg, busy); end
        keycode = 32'h0;
        tick();
        checks++; if (create !== 5'b00000 || state_dbg !== 2'd2) begin errors++; $display("FAIL basic_wait: got create=%b st=%0d want 00000 st=2", create, state_dbg); end
        tick();
        bullet_active = 5'b00001;
        tick();
        checks++; if (shots_fired !== 8'd1 || state_dbg !== 2'd3) begin errors++; $display("FAIL basic_ack: got shots=%0d st=%0d want 1 st=3", shots_fired, state_dbg); end
        repeat (11) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_cool11: got busy=%b want 1", busy); end
        tick();
        checks++; if (busy !== 1'b0 || state_dbg !== 2'd0) begin errors++; $display("FAIL basic_cool12: got busy=%b st=%0d want 0 st=0", busy, state_dbg); end
    endtask

    task automatic test_hold_key();
        int pulses;
        logic [4:0] last;
        pulses = 0; last = 5'b00000;
        keycode = 32'h2C00_0000;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (create !== 5'b00000) begin pulses++; last = create; end
            if (i == 2) bullet_active = 5'b00011;
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL hold_pulses: got %0d want 1", pulses); end
        checks++; if (last !== 5'b00010) begin errors++; $display("FAIL hold_slot: got %b want 00010", last); end
        checks++; if (shots_fired !== 8'd2 || state_dbg !== 2'd0) begin errors++; $display("FAIL hold_end: got shots=%0d st=%0d want 2 st=0", shots_fired, state_dbg); end
        keycode = 32'h0; bullet_active = 5'b00001;
        tick();
        keycode = 32'h2C00_0000;
        tick();
        checks++; if (create !== 5'b00010) begin errors++; $display("FAIL hold_repress: got %b want 00010", create); end
        keycode = 32'h0;
        repeat (5) tick();
        checks++; if (state_dbg !== 2'd0 || shots_fired !== 8'd2) begin errors++; $display("FAIL hold_timeout: got st=%0d shots=%0d want 0 2", state_dbg, shots_fired); end
    endtask

    task automatic test_no_free();
        bullet_active = 5'b11111;
        keycode = 32'h0000_002C;
        tick();
        checks++; if (create !== 5'b00000 || busy !== 1'b0) begin errors++; $display("FAIL nofree_drop: got create=%b busy=%b want 00000 0", create, busy); end
        keycode = 32'h0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nofree_idle: got busy=%b want 0", busy); end
        bullet_active = 5'b11011;
        keycode = 32'h002C_0000;
        tick();
        checks++; if (create !== 5'b00100 || busy !== 1'b1) begin errors++; $display("FAIL nofree_slot2: got create=%b busy=%b want 00100 1", create, busy); end
        keycode = 32'h0;
        repeat (5) tick();
        checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL nofree_ready: got st=%0d want 0", state_dbg); end
    endtask

    task automatic test_timeout();
        bullet_active = 5'b00000;
        keycode = 32'h0000_002C;
        tick();
        checks++; if (create !== 5'b00001) begin errors++; $display("FAIL to_create: got %b want 00001", create); end
        keycode = 32'h0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++; if (state_dbg !== 2'd2 || busy !== 1'b1) begin errors++; $display("FAIL to_wait%0d: got st=%0d busy=%b want 2 1", k, state_dbg, busy); end
        end
        tick();
        checks++; if (state_dbg !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL to_ready: got st=%0d busy=%b want 0 0", state_dbg, busy); end
        checks++; if (shots_fired !== 8'd2) begin errors++; $display("FAIL to_shots: got %0d want 2", shots_fired); end
        keycode = 32'h0000_002C;
        tick();
        checks++; if (create !== 5'b00001) begin errors++; $display("FAIL to_next_press: got %b want 00001", create); end
        keycode = 32'h0;
        repeat (5) tick();
    endtask

    task automatic test_cool_and_game_end();
        int pulses;
        bullet_active = 5'b00000;
        keycode = 32'h0000_002C;
        tick();
        keycode = 32'h0;
        tick();
        tick();
        bullet_active = 5'b00001;
        tick();
        checks++; if (state_dbg !== 2'd3 || shots_fired !== 8'd3) begin errors++; $display("FAIL cool_enter: got st=%0d shots=%0d want 3 3", state_dbg, shots_fired); end
        repeat (4) tick();
        keycode = 32'h0000_002C;
        tick();
        checks++; if (create !== 5'b00000 || state_dbg !== 2'd3) begin errors++; $display("FAIL cool_press: got create=%b st=%0d want 00000 3", create, state_dbg); end
        keycode = 32'h0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (create !== 5'b00000) pulses++;
        end
        checks++; if (pulses !== 0 || state_dbg !== 2'd3) begin errors++; $display("FAIL cool_hold: got pulses=%0d st=%0d want 0 3", pulses, state_dbg); end
        tick();
        checks++; if (state_dbg !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL cool_exit: got st=%0d busy=%b want 0 0", state_dbg, busy); end
        keycode = 32'h0000_002C;
        tick();
        checks++; if (create !== 5'b00010) begin errors++; $display("FAIL ge_fire: got %b want 00010", create); end
        keycode = 32'h0;
        tick();
        game_end = 2'b01;
        tick();
        checks++; if (state_dbg !== 2'd0 || create !== 5'b00000 || busy !== 1'b0) begin errors++; $display("FAIL ge_abort: got st=%0d create=%b busy=%b want 0 00000 0", state_dbg, create, busy); end
        keycode = 32'h0000_002C;
        tick();
        checks++; if (create !== 5'b00000 || state_dbg !== 2'd0) begin errors++; $display("FAIL ge_lock1: got create=%b st=%0d want 00000 0", create, state_dbg); end
        keycode = 32'h0;
        tick();
        keycode = 32'h0000_002C;
        tick();
        checks++; if (create !== 5'b00000 || shots_fired !== 8'd3) begin errors++; $display("FAIL ge_lock2: got create=%b shots=%0d want 00000 3", create, shots_fired); end
        game_end = 2'b00; keycode = 32'h0;
        tick();
        keycode = 32'h0000_002C;
        tick();
        checks++; if (create !== 5'b00010) begin errors++; $display("FAIL ge_release: got %b want 00010", create); end
        keycode = 32'h0;
        repeat (5) tick();
    endtask

    task automatic test_async_reset();
        bullet_active = 5'b00000;
        keycode = 32'h0000_002C;
        tick();
        checks++; if (create !== 5'b00001) begin errors++; $display("FAIL ar_fire: got %b want 00001", create); end
        #2;
        Reset_n = 1'b0;
        #1;
        checks++; if (create !== 5'b00000 || busy !== 1'b0) begin errors++; $display("FAIL ar_create: got create=%b busy=%b want 00000 0", create, busy); end
        checks++; if (shots_fired !== 8'd0 || state_dbg !== 2'd0) begin errors++; $display("FAIL ar_state: got shots=%0d st=%0d want 0 0", shots_fired, state_dbg); end
        keycode = 32'h0;
        #2;
        Reset_n = 1'b1;
        tick();
        keycode = 32'h0000_002C;
        tick();
        checks++; if (create !== 5'b00001) begin errors++; $display("FAIL ar_after: got %b want 00001", create); end
        keycode = 32'h0;
        tick();
    endtask

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Test sequence.
    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic_fire();
        test_hold_key();
        test_no_free();
        test_timeout();
        test_cool_and_game_end();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
